// File: rtl/fcc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fcc_pkg
// Brief    : Shared types and helpers for the fault-injection campaign sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fcc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DONE   = 3'd3,
        ST_REF    = 3'd4
    } fcc_state_e;

    typedef enum logic [1:0] {
        CL_TP = 2'd0,
        CL_TN = 2'd1,
        CL_FP = 2'd2,
        CL_FN = 2'd3
    } fcc_class_e;

    localparam int c_mod3_in_w = 32;

    function automatic logic [1:0] fcc_mod3(input logic [c_mod3_in_w-1:0] x);
        return 2'(x % 32'd3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fcc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : fcc_sat_counter
// Brief    : Result counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module fcc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fault_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fault_campaign_ctrl
// Brief    : Walks GID x stuck-at x A x B, drives the checked adder, classifies
//            each sampled result as TP/TN/FP/FN and keeps saturating counts.
// Options  : FCC_REF_PASS_EN adds a fault-free reference pass and ref_bad.
// Revision : 1.0 - initial release
// ============================================================================
module fault_campaign_ctrl
    import fcc_pkg::*;
#(
    parameter  int NG     = 128,
    parameter  int W      = 4,
    parameter  int SETTLE = 2,
    parameter  int CNT_W  = 16,
    localparam int GW     = $clog2(NG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GW-1:0]    gid_first,
    input  logic [GW-1:0]    gid_last,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic [1:0]       op_a_mod3,
    output logic [1:0]       op_b_mod3,
    output logic             op_cin,
    output logic [NG-1:0]    fault_en_bus,
    output logic             fault_val,
    input  logic [W:0]       sout_in,
    input  logic             err_in,
    output logic [CNT_W-1:0] tp,
    output logic [CNT_W-1:0] tn,
    output logic [CNT_W-1:0] fp,
    output logic [CNT_W-1:0] fn,
`ifdef FCC_REF_PASS_EN
    output logic             ref_bad,
`endif
    output logic             fn_valid,
    output logic [GW-1:0]    fn_gid,
    output logic             fn_sa,
    output logic [W-1:0]     fn_a,
    output logic [W-1:0]     fn_b
);

    localparam int c_sw = $clog2(SETTLE + 1);
`ifdef FCC_REF_PASS_EN
    localparam fcc_state_e c_first_state = ST_REF;
`else
    localparam fcc_state_e c_first_state = ST_APPLY;
`endif

    fcc_state_e       r_state;
    fcc_state_e       w_state_nxt;
    logic [GW-1:0]    r_gid;
    logic [GW-1:0]    r_gid_last;
    logic [GW-1:0]    w_gid_last_clamped;
    logic             r_sa;
    logic             r_cin;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [c_sw-1:0]  r_settle;
    logic             r_fn_valid;
    logic [GW-1:0]    r_fn_gid;
    logic             r_fn_sa;
    logic [W-1:0]     r_fn_a;
    logic [W-1:0]     r_fn_b;

    logic [W:0]       w_ref;
    logic             w_mismatch;
    fcc_class_e       w_class;
    logic             w_start;
    logic             w_empty;
    logic             w_sample;
    logic             w_last_ab;
    logic             w_last_tuple;
    logic             w_settle_end;
    logic [NG-1:0]    w_onehot;

    // A power-of-two NG already bounds gid_last through its width.
    generate
        if (NG == (1 << GW)) begin : g_clamp_pow2
            assign w_gid_last_clamped = gid_last;
        end else begin : g_clamp_sat
            assign w_gid_last_clamped = (gid_last > GW'(NG - 1)) ? GW'(NG - 1) : gid_last;
        end
    endgenerate

    assign w_start      = (r_state == ST_IDLE) && start;
    assign w_empty      = gid_first > w_gid_last_clamped;
    assign w_sample     = (r_state == ST_SAMPLE);
    assign w_last_ab    = &{r_a, r_b};
    assign w_last_tuple = w_last_ab && r_sa && (r_gid == r_gid_last);
    assign w_settle_end = (r_settle == c_sw'(SETTLE - 1));
    assign w_onehot     = {{(NG-1){1'b0}}, 1'b1} << r_gid;

    assign w_ref      = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_cin};
    assign w_mismatch = (w_ref != sout_in);

    always_comb begin
        w_class = CL_TN;
        case ({w_mismatch, err_in})
            2'b10:   w_class = CL_FN;
            2'b11:   w_class = CL_TP;
            2'b01:   w_class = CL_FP;
            default: w_class = CL_TN;
        endcase
    end

`ifdef FCC_REF_PASS_EN
    logic r_ref_bad;
    logic w_ref_sample;

    // Reference vectors sample in the same state, on the cycle after settling.
    assign w_ref_sample = (r_state == ST_REF) && (r_settle == c_sw'(SETTLE));
    assign ref_bad      = r_ref_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_empty ? ST_DONE : c_first_state;
                end
            end
            ST_APPLY: begin
                if (w_settle_end) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: w_state_nxt = w_last_tuple ? ST_DONE : ST_APPLY;
            ST_DONE:   w_state_nxt = ST_IDLE;
`ifdef FCC_REF_PASS_EN
            ST_REF: begin
                if (w_ref_sample && w_last_ab) begin
                    w_state_nxt = ST_APPLY;
                end
            end
`endif
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        fault_en_bus = '0;
        case (r_state)
            ST_APPLY, ST_SAMPLE: begin
                busy         = 1'b1;
                fault_en_bus = w_onehot;
            end
            ST_REF:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gid      <= '0;
            r_gid_last <= '0;
            r_sa       <= 1'b0;
            r_cin      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_settle   <= '0;
            r_fn_valid <= 1'b0;
            r_fn_gid   <= '0;
            r_fn_sa    <= 1'b0;
            r_fn_a     <= '0;
            r_fn_b     <= '0;
`ifdef FCC_REF_PASS_EN
            r_ref_bad  <= 1'b0;
`endif
        end else begin
            r_fn_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_gid      <= gid_first;
                        r_gid_last <= w_gid_last_clamped;
                        r_sa       <= 1'b0;
                        r_a        <= '0;
                        r_b        <= '0;
                        r_settle   <= '0;
                        r_cin      <= cin;
`ifdef FCC_REF_PASS_EN
                        r_ref_bad  <= 1'b0;
`endif
                    end
                end
                ST_APPLY: begin
                    r_settle <= w_settle_end ? '0 : r_settle + c_sw'(1);
                end
                ST_SAMPLE: begin
                    // b is the fastest digit, then a, then stuck-at value, then GID.
                    {r_a, r_b} <= {r_a, r_b} + (2*W)'(1);
                    if (w_last_ab) begin
                        r_sa <= ~r_sa;
                        if (r_sa) begin
                            r_gid <= r_gid + GW'(1);
                        end
                    end
                    if (w_class == CL_FN) begin
                        r_fn_valid <= 1'b1;
                        r_fn_gid   <= r_gid;
                        r_fn_sa    <= r_sa;
                        r_fn_a     <= r_a;
                        r_fn_b     <= r_b;
                    end
                end
`ifdef FCC_REF_PASS_EN
                ST_REF: begin
                    if (w_ref_sample) begin
                        r_settle   <= '0;
                        {r_a, r_b} <= {r_a, r_b} + (2*W)'(1);
                        if (w_mismatch || err_in) begin
                            r_ref_bad <= 1'b1;
                        end
                    end else begin
                        r_settle <= r_settle + c_sw'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign op_a      = r_a;
    assign op_b      = r_b;
    assign op_cin    = r_cin;
    assign fault_val = r_sa;
    assign op_a_mod3 = fcc_mod3(c_mod3_in_w'(r_a));
    assign op_b_mod3 = fcc_mod3(c_mod3_in_w'(r_b));
    assign fn_valid  = r_fn_valid;
    assign fn_gid    = r_fn_gid;
    assign fn_sa     = r_fn_sa;
    assign fn_a      = r_fn_a;
    assign fn_b      = r_fn_b;

    fcc_sat_counter #(.CNT_W(CNT_W)) u_cnt_tp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .inc   (w_sample && (w_class == CL_TP)),
        .count (tp)
    );

    fcc_sat_counter #(.CNT_W(CNT_W)) u_cnt_tn (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .inc   (w_sample && (w_class == CL_TN)),
        .count (tn)
    );

    fcc_sat_counter #(.CNT_W(CNT_W)) u_cnt_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .inc   (w_sample && (w_class == CL_FP)),
        .count (fp)
    );

    fcc_sat_counter #(.CNT_W(CNT_W)) u_cnt_fn (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start),
        .inc   (w_sample && (w_class == CL_FN)),
        .count (fn)
    );

endmodule
`default_nettype wire

// File: tb/tb_fault_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_campaign_ctrl
// Brief    : Campaign table plus reset-abort sequence for fault_campaign_ctrl;
//            a 16-bit and an 8-bit counter build run side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fault_campaign_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   gid_first = '0;
    logic [6:0]   gid_last = '0;
    logic         cin = 1'b0;

    logic         busy, done, op_cin, fault_val, err_in, fn_valid, fn_sa;
    logic [3:0]   op_a, op_b, fn_a, fn_b;
    logic [1:0]   op_a_mod3, op_b_mod3;
    logic [127:0] fault_en_bus;
    logic [4:0]   sout_in;
    logic [15:0]  tp, tn, fp, fn;
    logic [6:0]   fn_gid;

    logic         s_busy, s_done, s_op_cin, s_fault_val, s_err_in, s_fn_valid, s_fn_sa;
    logic [3:0]   s_op_a, s_op_b, s_fn_a, s_fn_b;
    logic [1:0]   s_op_a_mod3, s_op_b_mod3;
    logic [127:0] s_fault_en_bus;
    logic [4:0]   s_sout_in;
    logic [7:0]   s_tp, s_tn, s_fp, s_fn;
    logic [6:0]   s_fn_gid;
`ifdef FCC_REF_PASS_EN
    logic         ref_bad, s_ref_bad;
`endif

    int           env_mode = 0;
    int unsigned  env_seed = 0;
    int           cyc = 0;
    int           n_pass = 0;
    int           n_total = 0;
    logic [15:0]  fn_q[$];

    typedef struct {
        int          first;
        int          last;
        logic        cin;
        int          mode;
        int unsigned seed;
        int          e_tp;
        int          e_tn;
        int          e_fp;
        int          e_fn;
    } row_t;

    row_t rows[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fault_campaign_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gid_first(gid_first), .gid_last(gid_last),
        .cin(cin), .busy(busy), .done(done), .op_a(op_a), .op_b(op_b),
        .op_a_mod3(op_a_mod3), .op_b_mod3(op_b_mod3), .op_cin(op_cin),
        .fault_en_bus(fault_en_bus), .fault_val(fault_val), .sout_in(sout_in), .err_in(err_in),
        .tp(tp), .tn(tn), .fp(fp), .fn(fn),
`ifdef FCC_REF_PASS_EN
        .ref_bad(ref_bad),
`endif
        .fn_valid(fn_valid), .fn_gid(fn_gid), .fn_sa(fn_sa), .fn_a(fn_a), .fn_b(fn_b)
    );

    fault_campaign_ctrl #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .gid_first(gid_first), .gid_last(gid_last),
        .cin(cin), .busy(s_busy), .done(s_done), .op_a(s_op_a), .op_b(s_op_b),
        .op_a_mod3(s_op_a_mod3), .op_b_mod3(s_op_b_mod3), .op_cin(s_op_cin),
        .fault_en_bus(s_fault_en_bus), .fault_val(s_fault_val), .sout_in(s_sout_in), .err_in(s_err_in),
        .tp(s_tp), .tn(s_tn), .fp(s_fp), .fn(s_fn),
`ifdef FCC_REF_PASS_EN
        .ref_bad(s_ref_bad),
`endif
        .fn_valid(s_fn_valid), .fn_gid(s_fn_gid), .fn_sa(s_fn_sa), .fn_a(s_fn_a), .fn_b(s_fn_b)
    );

    function automatic int onehot_idx(logic [127:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 128; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int unsigned mix(int unsigned seed, int gid, logic sa, logic [3:0] a, logic [3:0] b);
        int unsigned h;
        h = seed ^ (32'(gid) << 9) ^ (32'(sa) << 8) ^ {24'd0, a, b};
        h = h * 32'h9E3779B1;
        h = h ^ (h >> 16);
        h = h * 32'h85EBCA6B;
        h = h ^ (h >> 13);
        return h;
    endfunction

    // Behaviour of the checked adder seen by the sequencer, as {err, sum}.
    function automatic logic [5:0] env_fn(int mode, int unsigned seed, int gid, logic sa,
                                          logic [3:0] a, logic [3:0] b, logic c);
        logic [4:0]  r, s;
        logic        e;
        int unsigned h;
        r = 5'(a) + 5'(b) + 5'(c);
        s = r;
        e = 1'b0;
        case (mode)
            1: begin s = r + 5'd1; e = 1'b1; end
            2: if (a == 4'd3 && b == 4'd5) s = r ^ 5'd1;
            3: begin
                h = mix(seed, gid, sa, a, b);
                if (h[1:0] == 2'b00) s = r ^ (5'(h[6:2]) | 5'd1);
                e = h[12] & h[13];
            end
            default: ;
        endcase
        return {e, s};
    endfunction

    always_comb {err_in, sout_in} = env_fn(env_mode, env_seed, onehot_idx(fault_en_bus),
                                           fault_val, op_a, op_b, op_cin);
    always_comb {s_err_in, s_sout_in} = env_fn(env_mode, env_seed, onehot_idx(s_fault_en_bus),
                                               s_fault_val, s_op_a, s_op_b, s_op_cin);

    // Whole-campaign expectation from the classification rules; fills fn_q in order.
    task automatic model(input int first, input int last, input logic c, input int mode,
                         input int unsigned seed, output int m_tp, output int m_tn,
                         output int m_fp, output int m_fn);
        logic [5:0] o;
        logic [4:0] rf;
        m_tp = 0; m_tn = 0; m_fp = 0; m_fn = 0;
        fn_q.delete();
        for (int g = first; g <= last; g++)
            for (int sa = 0; sa < 2; sa++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        rf = 5'(a + b + int'(c));
                        o  = env_fn(mode, seed, g, sa[0], 4'(a), 4'(b), c);
                        if (o[4:0] != rf) begin
                            if (o[5]) m_tp++;
                            else begin
                                m_fn++;
                                fn_q.push_back({7'(g), sa[0], 4'(a), 4'(b)});
                            end
                        end else if (o[5]) m_fp++;
                        else m_tn++;
                    end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    function automatic int sat8(int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic run_row(input row_t rw, input string tag);
        int m_tp, m_tn, m_fp, m_fn, nvec, t0, busy_cyc, done_cyc, bus_err, mod_err, fn_err, gi;
        bit seen_busy, got_done;
        logic [15:0] fe;
        model(rw.first, rw.last, rw.cin, rw.mode, rw.seed, m_tp, m_tn, m_fp, m_fn);
        env_mode = rw.mode;
        env_seed = rw.seed;
        nvec = (rw.first > rw.last) ? 0 : (rw.last - rw.first + 1) * 512;
        busy_cyc = 0; done_cyc = 0; bus_err = 0; mod_err = 0; fn_err = 0;
        seen_busy = 0; got_done = 0;
        @(negedge clk);
        gid_first = 7'(rw.first);
        gid_last  = 7'(rw.last);
        cin       = rw.cin;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < nvec * 3 + 10; k++) begin
            if (busy && !seen_busy) begin seen_busy = 1; busy_cyc = cyc; end
            if (busy) begin
                gi = onehot_idx(fault_en_bus);
                if (!$onehot(fault_en_bus) || gi < rw.first || gi > rw.last) bus_err++;
                if (op_cin !== rw.cin) bus_err++;
            end else if (fault_en_bus != '0) bus_err++;
            if (op_a_mod3 !== 2'(op_a % 3) || op_b_mod3 !== 2'(op_b % 3)) mod_err++;
            if (fn_valid) begin
                if (fn_q.size() == 0) fn_err++;
                else begin
                    fe = fn_q.pop_front();
                    if ({fn_gid, fn_sa, fn_a, fn_b} !== fe) fn_err++;
                end
            end
            if (done) begin got_done = 1; done_cyc = cyc; break; end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
        if (nvec > 0) begin
            chk({tag, "_latency"}, 64'(done_cyc - busy_cyc), 64'(nvec * 3));
        end else begin
            chk({tag, "_empty_latency_le2"}, 64'((done_cyc - t0) <= 2), 64'd1);
            chk({tag, "_empty_no_busy"}, 64'(seen_busy), 64'd0);
        end
        chk({tag, "_fault_bus_errs"}, 64'(bus_err), 64'd0);
        chk({tag, "_mod3_errs"}, 64'(mod_err), 64'd0);
        chk({tag, "_fn_report_errs"}, 64'(fn_err), 64'd0);
        chk({tag, "_fn_missing"}, 64'(fn_q.size()), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
        chk({tag, "_tp"}, 64'(tp), 64'(rw.e_tp));
        chk({tag, "_tn"}, 64'(tn), 64'(rw.e_tn));
        chk({tag, "_fp"}, 64'(fp), 64'(rw.e_fp));
        chk({tag, "_fn"}, 64'(fn), 64'(rw.e_fn));
        chk({tag, "_tp8"}, 64'(s_tp), 64'(sat8(rw.e_tp)));
        chk({tag, "_tn8"}, 64'(s_tn), 64'(sat8(rw.e_tn)));
        chk({tag, "_fp8"}, 64'(s_fp), 64'(sat8(rw.e_fp)));
        chk({tag, "_fn8"}, 64'(s_fn), 64'(sat8(rw.e_fn)));
    endtask

    initial begin
        int d_tp, d_tn, d_fp, d_fn, f;
        rows[0] = '{30, 30, 1'b0, 0, 0, 0, 512, 0, 0};
        rows[1] = '{5, 6, 1'b1, 1, 0, 1024, 0, 0, 0};
        rows[2] = '{7, 7, 1'b0, 2, 0, 0, 510, 0, 2};
        rows[3] = '{10, 4, 1'b0, 0, 0, 0, 0, 0, 0};
        rows[4] = '{0, 0, 1'b0, 0, 0, 0, 512, 0, 0};
        for (int i = 5; i < 8; i++) begin
            f = (i == 5) ? 127 : int'($urandom_range(0, 126));
            rows[i].first = f;
            rows[i].last  = (i == 7) ? f + 1 : f;
            rows[i].cin   = 1'($urandom_range(0, 1));
            rows[i].mode  = 3;
            rows[i].seed  = $urandom;
            model(rows[i].first, rows[i].last, rows[i].cin, 3, rows[i].seed, d_tp, d_tn, d_fp, d_fn);
            rows[i].e_tp = d_tp; rows[i].e_tn = d_tn; rows[i].e_fp = d_fp; rows[i].e_fn = d_fn;
        end

        repeat (3) @(negedge clk);
        chk("rst_busy_done", 64'({busy, done, fn_valid}), 64'd0);
        chk("rst_fault_bus", 64'(fault_en_bus != '0), 64'd0);
        chk("rst_ops", 64'({op_a, op_b, op_cin, fault_val, op_a_mod3, op_b_mod3}), 64'd0);
        chk("rst_counters", 64'({tp, tn, fp, fn}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_row(rows[i], $sformatf("row%0d", i));

        // Abort a campaign part-way through gid 20 with an asynchronous reset.
        env_mode = 0;
        @(negedge clk);
        gid_first = 7'd20;
        gid_last  = 7'd22;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_midrun_gid", 64'(onehot_idx(fault_en_bus)), 64'd20);
        chk("abort_midrun_tn_nonzero", 64'(tn != '0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bus_cleared", 64'(fault_en_bus != '0), 64'd0);
        chk("abort_busy_cleared", 64'(busy), 64'd0);
        chk("abort_counters_cleared", 64'({tp, tn, fp, fn}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_row(rows[0], "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
